// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - shares one multi-cycle main memory between I-fills, D-fills and write-through stores
module cache_fill_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               icache_miss,
    input  logic [ADDR_W-1:0]                  icache_miss_addr,
    input  logic                               dcache_miss,
    input  logic [ADDR_W-1:0]                  dcache_miss_addr,
    input  logic                               dmem_wr_req,
    input  logic [ADDR_W-1:0]                  dmem_wr_addr,
    input  logic [15:0]                        dmem_wr_data,
    input  logic                               mem_data_valid,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [15:0]                        mem_data_in,
    output logic                               fill_we_i,
    output logic                               fill_we_d,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word_idx,
    output logic                               fill_done_i,
    output logic                               fill_done_d,
    output logic                               dmem_wr_ack,
    output logic                               istall,
    output logic                               dstall
);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W:0]    ISSUE_END  = (IDX_W + 1)'(WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] BLOCK_MASK = ~ADDR_W'((2 * WORDS_PER_BLOCK) - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL_D,
        FILL_I,
        WRITE
    } state_t;

    state_t             state;
    logic [IDX_W:0]     issue_cnt;
    logic [IDX_W-1:0]   ret_cnt;
    logic [ADDR_W-1:0]  base;

    logic in_fill;
    logic issuing;
    logic fill_ret;
    logic last_ret;

    assign in_fill  = (state == FILL_D) || (state == FILL_I);
    assign issuing  = in_fill && (issue_cnt < ISSUE_END);
    assign fill_ret = in_fill && mem_data_valid;
    assign last_ret = fill_ret && (ret_cnt == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            base      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // D-miss first: a stalled MEM stage blocks retirement of everything behind it
                    if (dcache_miss) begin
                        base      <= dcache_miss_addr & BLOCK_MASK;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= FILL_D;
                    end else if (dmem_wr_req) begin
                        state <= WRITE;
                    end else if (icache_miss) begin
                        base      <= icache_miss_addr & BLOCK_MASK;
                        issue_cnt <= '0;
                        ret_cnt   <= '0;
                        state     <= FILL_I;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                FILL_D, FILL_I: begin
                    if (issuing) begin
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (fill_ret) begin
                        ret_cnt <= ret_cnt + 1'b1;
                    end
                    if (last_ret) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (state == WRITE) begin
            mem_en      = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = dmem_wr_addr;
            mem_data_in = dmem_wr_data;
        end else if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
        end
    end

    assign dmem_wr_ack   = (state == WRITE);
    assign fill_we_i     = fill_ret && (state == FILL_I);
    assign fill_we_d     = fill_ret && (state == FILL_D);
    assign fill_done_i   = last_ret && (state == FILL_I);
    assign fill_done_d   = last_ret && (state == FILL_D);
    assign fill_word_idx = fill_ret ? ret_cnt : '0;

    assign istall = icache_miss || (state == FILL_I);
    assign dstall = dcache_miss || (state == FILL_D) || (dmem_wr_req && !dmem_wr_ack);
endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Sequences and shares the single multi-cycle main memory between I-cache miss fills, D-cache miss fills and D-cache write-through stores.
- Sits between both caches and main memory. Produces the fill write strobes for each cache and the stall signals that freeze the pipeline: the fetch stage on `istall`, and the MEM/WB registers via their write-enable on `dstall`.
- One transaction owns memory at a time.

Parameters:
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two.
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- icache_miss  in  1  I-cache miss; held high until fill_done_i
- icache_miss_addr  in  16  byte address of missing fetch
- dcache_miss  in  1  D-cache load miss; held high until fill_done_d
- dcache_miss_addr  in  16  byte address of missing load
- dmem_wr_req  in  1  write-through store request; held until dmem_wr_ack
- dmem_wr_addr  in  16  store byte address
- dmem_wr_data  in  16  store data
- mem_data_valid  in  1  main memory returning a read word this cycle
- mem_en  out  1  main memory access enable
- mem_wr  out  1  main memory write (valid with mem_en)
- mem_addr  out  16  main memory byte address
- mem_data_in  out  16  write data to memory
- fill_we_i  out  1  write returning word into I-cache data array
- fill_we_d  out  1  write returning word into D-cache data array
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  word offset of returning word
- fill_done_i  out  1  last I-fill word; I-cache writes tag/valid
- fill_done_d  out  1  last D-fill word; D-cache writes tag/valid
- dmem_wr_ack  out  1  store accepted by memory
- istall  out  1  fetch stall
- dstall  out  1  MEM-stage stall (drives MEM/WB WEN inverted)

Behaviour:
- Registered state: IDLE, FILL_D, FILL_I, WRITE. Also an issue counter (0..WORDS_PER_BLOCK), a return counter (0..WORDS_PER_BLOCK-1) and a latched 16-bit block base.
- Reset (async): state IDLE, both counters 0, base 0.
  - All outputs are 0 except where a combinational stall term is driven directly by an input (see stall equations).
  - Reset mid-fill aborts the fill. No fill_we or fill_done is produced afterwards. Later mem_data_valid pulses are ignored until a new fill starts.
- IDLE arbitration is evaluated each cycle; priority is dcache_miss > dmem_wr_req > icache_miss.
  - Grant to a fill: base <= miss_addr with the low log2(2*WORDS_PER_BLOCK) bits cleared; counters <= 0; go to FILL_D or FILL_I.
  - Grant to a store: go to WRITE.
  - No request: stay in IDLE.
  - mem_data_valid is ignored in IDLE and WRITE.
- WRITE (exactly 1 cycle):
  - Outputs: mem_en=1, mem_wr=1, mem_addr=dmem_wr_addr, mem_data_in=dmem_wr_data, dmem_wr_ack=1.
  - Next state IDLE. A store therefore occupies 2 cycles from request to release.
- FILL_x, issue side:
  - While issue counter < WORDS_PER_BLOCK: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, and the issue counter increments.
  - Afterwards mem_en=0.
- FILL_x, return side:
  - On mem_data_valid, fill_we_x=1 and fill_word_idx=return counter, then the return counter increments.
  - When mem_data_valid arrives with return counter = WORDS_PER_BLOCK-1: fill_done_x=1 in that same cycle, and the next state is IDLE.
  - Memory latency is not assumed; completion is driven only by the 8 valid pulses.
- Addition for mem_addr wraps modulo 2^16. A block at 0xFFF0 issues 0xFFF0..0xFFFE.
- fill_we_i/fill_done_i are asserted only in FILL_I, and fill_we_d/fill_done_d only in FILL_D. These signals are never asserted simultaneously.
- Stall equations (combinational):
  - istall = icache_miss | (state==FILL_I).
  - dstall = dcache_miss | (state==FILL_D) | (dmem_wr_req & ~dmem_wr_ack).
- Simultaneous I-miss and D-miss in IDLE: the D fill is served fully first. The I-miss remains asserted (istall high throughout) and is granted in the IDLE cycle following fill_done_d.
- A request arriving during a fill or write waits. No preemption.
- Mem output values are don't-care when mem_en=0; drive 0.

Test Plan:
- I-miss only, addr 0x1236, memory latency 4 → mem_en cycles 1–8 with addresses 0x1230,0x1232,…,0x123E. fill_we_i with idx 0..7 on cycles 5–12. fill_done_i on cycle 12. State IDLE on cycle 13. istall high cycles 0–12.
- I-miss 0x0040 and D-miss 0x8008 raised same cycle → D fill first (addresses 0x8000..0x800E, fill_we_d only). fill_done_d precedes any I access. Then I fill of 0x0040..0x004E. istall high continuously throughout.
- Store 0x2002←0xBEEF in IDLE → next cycle mem_en=1, mem_wr=1, mem_addr=0x2002, mem_data_in=0xBEEF, dmem_wr_ack=1. dstall high only in the request cycle; IDLE the cycle after.
- Store requested during an I fill → no mem_wr until after fill_done_i. WRITE follows in the next IDLE cycle, and dstall is held until the ack.
- rst pulsed at fill word 3 → outputs go to 0 immediately. Subsequent stray mem_data_valid pulses produce no fill_we. A new D-miss 0x0100 fills cleanly with idx 0..7.
- D-miss at 0xFFF4 → addresses 0xFFF0..0xFFFE, no carry out. Irregular mem_data_valid gaps (e.g. 1,0,1,1,0,…) still give idx 0..7 in order and fill_done_d on the 8th pulse.
